// File: rtl/pen_slot_allocator_pkg.sv
// pen_slot_allocator_pkg: shared defaults, lane record and popcount helper for the slot allocator.
package pen_slot_allocator_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_N         = 3;
    localparam int DEF_LOG_WIDTH = $clog2(DEF_WIDTH);

    typedef struct packed {
        logic                     valid;
        logic [DEF_LOG_WIDTH-1:0] index;
    } lane_t;

    function automatic int popcount(input logic [63:0] vec);
        popcount = 0;
        for (int i = 0; i < 64; i++) popcount += int'(vec[i]);
    endfunction

endpackage

// File: rtl/pen_slot_allocator_lsb_for.sv
// pen_lsb_for: picks the N lowest set bits of req_vec as ascending one-hot grants.
module pen_lsb_for #(
    parameter int WIDTH = 8,
    parameter int N     = 3
) (
    input  logic [WIDTH-1:0]        req_vec,
    output logic [N-1:0]            ack_valid_by_n,
    output logic [N-1:0][WIDTH-1:0] ack_one_hot_by_n
);

    logic [WIDTH-1:0] rest;

    always_comb begin
        rest = req_vec;
        for (int n = 0; n < N; n++) begin
            ack_one_hot_by_n[n] = rest & (~rest + WIDTH'(1));
            ack_valid_by_n[n]   = |rest;
            rest                = rest & ~ack_one_hot_by_n[n];
        end
    end

endmodule

// File: rtl/pen_slot_allocator.sv
// pen_slot_allocator: free-list allocator feeding an N-lane in-order allocation buffer.
// Optional sticky alloc_error output under PEN_SLOT_ALLOCATOR_ERROR_EN.
module pen_slot_allocator
    import pen_slot_allocator_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int N         = DEF_N,
    parameter int LOG_WIDTH = $clog2(WIDTH),
    parameter int LOG_N1    = $clog2(N + 1)
) (
    input  logic                      CLK,
    input  logic                      nRST,
    output logic [N-1:0]              alloc_valid_by_n,
    output logic [N-1:0][LOG_WIDTH-1:0] alloc_index_by_n,
    input  logic [LOG_N1-1:0]         alloc_take_count,
    input  logic [N-1:0]              dealloc_valid_by_n,
    input  logic [N-1:0][LOG_WIDTH-1:0] dealloc_index_by_n,
    output logic [LOG_WIDTH:0]        free_count
`ifdef PEN_SLOT_ALLOCATOR_ERROR_EN
    ,
    output logic                      alloc_error
`endif
);

    lane_t                     lanes_q [N];
    lane_t                     lanes_d [N];
    logic [WIDTH-1:0]          free_q, free_d, used, dmask;
    logic [N-1:0]              ack_valid;
    logic [N-1:0][WIDTH-1:0]   ack_oh;
    logic [LOG_WIDTH-1:0]      grant_idx [N];
    logic                      held, legal;
    int                        v, t, rem;

    pen_lsb_for #(.WIDTH(WIDTH), .N(N)) u_lsb_for (
        .req_vec          (free_q),
        .ack_valid_by_n   (ack_valid),
        .ack_one_hot_by_n (ack_oh)
    );

    always_comb begin
        v = 0;
        for (int k = 0; k < N; k++) v += int'(lanes_q[k].valid);
        t   = (int'(alloc_take_count) > v) ? v : int'(alloc_take_count);
        rem = v - t;
        for (int g = 0; g < N; g++) begin
            grant_idx[g] = '0;
            for (int b = 0; b < WIDTH; b++) grant_idx[g] |= ack_oh[g][b] ? LOG_WIDTH'(b) : '0;
        end
        used = '0;
        for (int k = 0; k < N; k++) begin
            lanes_d[k] = '0;
            for (int j = 0; j < N; j++) if (k < rem && j == k + t) lanes_d[k] = lanes_q[j];
            for (int g = 0; g < N; g++) begin
                if (k >= rem && k == rem + g && ack_valid[g]) begin
                    lanes_d[k] = '{valid: 1'b1, index: grant_idx[g]};
                    used       = used | ack_oh[g];
                end
            end
        end
    end

    // A dealloc only counts for a slot that is neither free nor parked in a lane.
`ifdef PEN_SLOT_ALLOCATOR_ERROR_EN
    logic illegal, err_q, err_d;
`endif

    always_comb begin
        dmask = '0;
`ifdef PEN_SLOT_ALLOCATOR_ERROR_EN
        illegal = 1'b0;
`endif
        for (int p = 0; p < N; p++) begin
            held = 1'b0;
            for (int k = 0; k < N; k++) held |= lanes_q[k].valid && lanes_q[k].index == dealloc_index_by_n[p];
            legal = dealloc_valid_by_n[p] && !free_q[dealloc_index_by_n[p]] && !held;
            if (legal) dmask[dealloc_index_by_n[p]] = 1'b1;
`ifdef PEN_SLOT_ALLOCATOR_ERROR_EN
            illegal |= dealloc_valid_by_n[p] && !legal;
`endif
        end
        free_d = (free_q & ~used) | dmask;
    end

`ifdef PEN_SLOT_ALLOCATOR_ERROR_EN
    always_comb err_d = err_q | illegal | (int'(alloc_take_count) > v) | (int'(alloc_take_count) > N);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign alloc_error = err_q;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            free_q <= '1;
            for (int k = 0; k < N; k++) lanes_q[k] <= '0;
        end else begin
            free_q <= free_d;
            for (int k = 0; k < N; k++) lanes_q[k] <= lanes_d[k];
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            alloc_valid_by_n[k] = lanes_q[k].valid;
            alloc_index_by_n[k] = lanes_q[k].index;
        end
        free_count = (LOG_WIDTH + 1)'(popcount(64'(free_q)));
    end

endmodule

// File: tb/tb_pen_slot_allocator.sv
// tb_pen_slot_allocator: directed plan plus randomized traffic against a queue-based free-list model.
// Checks alloc_error too when PEN_SLOT_ALLOCATOR_ERROR_EN is defined.
module tb_pen_slot_allocator;

    localparam int WIDTH = 8;
    localparam int N     = 3;
    localparam int LW    = 3;
    localparam int LN1   = 2;

    logic               CLK = 1'b0;
    logic               nRST = 1'b0;
    logic [N-1:0]       alloc_valid_by_n;
    logic [N-1:0][LW-1:0] alloc_index_by_n;
    logic [LN1-1:0]     alloc_take_count = '0;
    logic [N-1:0]       dealloc_valid_by_n = '0;
    logic [N-1:0][LW-1:0] dealloc_index_by_n = '0;
    logic [LW:0]        free_count;
`ifdef PEN_SLOT_ALLOCATOR_ERROR_EN
    logic               alloc_error;
`endif

    int checks = 0;
    int errors = 0;
    int q[$];
    bit free_m[WIDTH];
    bit err_m;

    always #5 CLK = ~CLK;

    pen_slot_allocator dut (
        .CLK                (CLK),
        .nRST               (nRST),
        .alloc_valid_by_n   (alloc_valid_by_n),
        .alloc_index_by_n   (alloc_index_by_n),
        .alloc_take_count   (alloc_take_count),
        .dealloc_valid_by_n (dealloc_valid_by_n),
        .dealloc_index_by_n (dealloc_index_by_n),
        .free_count         (free_count)
`ifdef PEN_SLOT_ALLOCATOR_ERROR_EN
        ,
        .alloc_error        (alloc_error)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (free_m[i]) free_m[i] = 1'b1;
        err_m = 1'b0;
    endtask

    // Lanes are an ordered queue; refill takes the lowest free slots from the pre-edge free set.
    task automatic model_step(input int take, input logic [N-1:0] dv, input logic [N-1:0][LW-1:0] di);
        int v = q.size();
        int t = take < v ? take : v;
        bit dm[WIDTH];
        bit bad = 1'b0;
        for (int p = 0; p < N; p++) begin
            if (dv[p]) begin
                bit in_lane = 1'b0;
                foreach (q[k]) if (q[k] == int'(di[p])) in_lane = 1'b1;
                if (free_m[di[p]] || in_lane) bad = 1'b1;
                else dm[di[p]] = 1'b1;
            end
        end
        repeat (t) void'(q.pop_front());
        for (int i = 0; i < WIDTH; i++) begin
            if (free_m[i] && q.size() < N) begin
                q.push_back(i);
                free_m[i] = 1'b0;
            end
        end
        for (int i = 0; i < WIDTH; i++) if (dm[i]) free_m[i] = 1'b1;
        err_m |= bad || take > v || take > N;
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0]   ev = '0;
        logic [3*N-1:0] ei = '0;
        int fc = 0;
        foreach (q[k]) begin
            ev[k] = 1'b1;
            ei[k*LW +: LW] = LW'(q[k]);
        end
        foreach (free_m[i]) fc += int'(free_m[i]);
        chk({tag, "_valid"}, 16'(alloc_valid_by_n), 16'(ev));
        chk({tag, "_index"}, 16'(alloc_index_by_n), 16'(ei));
        chk({tag, "_free"}, 16'(free_count), 16'(fc));
`ifdef PEN_SLOT_ALLOCATOR_ERROR_EN
        chk({tag, "_err"}, 16'(alloc_error), 16'(err_m));
`endif
    endtask

    task automatic step(input string tag, input int take, input logic [N-1:0] dv,
                        input int i0, input int i1, input int i2);
        logic [N-1:0][LW-1:0] di;
        di[0] = LW'(i0);
        di[1] = LW'(i1);
        di[2] = LW'(i2);
        alloc_take_count   = LN1'(take);
        dealloc_valid_by_n = dv;
        dealloc_index_by_n = di;
        model_step(take, dv, di);
        @(posedge CLK);
        @(negedge CLK);
        alloc_take_count   = '0;
        dealloc_valid_by_n = '0;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 16'(alloc_valid_by_n), 16'h0);
        chk("rst_index", 16'(alloc_index_by_n), 16'h0);
        chk("rst_free", 16'(free_count), 16'd8);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge CLK);
        chk("rst_valid", 16'(alloc_valid_by_n), 16'h0);
        chk("rst_free", 16'(free_count), 16'd8);
        nRST = 1'b1;

        step("boot", 0, 3'b000, 0, 0, 0);
        chk("boot_lanes", 16'(alloc_index_by_n), 16'({3'd2, 3'd1, 3'd0}));
        chk("boot_free5", 16'(free_count), 16'd5);
        step("take2", 2, 3'b000, 0, 0, 0);
        chk("take2_lanes", 16'(alloc_index_by_n), 16'({3'd4, 3'd3, 3'd2}));
        step("take3a", 3, 3'b000, 0, 0, 0);
        chk("take3a_lanes", 16'(alloc_index_by_n), 16'({3'd7, 3'd6, 3'd5}));
        step("take3b", 3, 3'b000, 0, 0, 0);
        step("take3c", 3, 3'b000, 0, 0, 0);
        chk("empty_valid", 16'(alloc_valid_by_n), 16'h0);
        step("free61", 0, 3'b011, 6, 1, 0);
        chk("free61_cnt", 16'(free_count), 16'd2);
        step("refill16", 0, 3'b000, 0, 0, 0);
        chk("refill16_valid", 16'(alloc_valid_by_n), 16'b011);
        step("tk1_free3", 1, 3'b001, 3, 0, 0);
        chk("tk1_lane6", 16'(alloc_index_by_n), 16'd6);
        step("refill3", 0, 3'b000, 0, 0, 0);
        step("held6", 0, 3'b001, 6, 0, 0);
        step("hold", 0, 3'b000, 0, 0, 0);

        do_reset();
        step("boot2", 0, 3'b000, 0, 0, 0);
        step("held0", 0, 3'b001, 0, 0, 0);
        do_reset();
        step("boot3", 1, 3'b000, 0, 0, 0);
        step("dup_free", 1, 3'b111, 0, 0, 5);
        step("dup_chk", 0, 3'b000, 0, 0, 0);

        for (int r = 0; r < 400; r++) begin
            int owned[$];
            int idx[N];
            logic [N-1:0] dv = '0;
            if (r == 200) do_reset();
            for (int i = 0; i < WIDTH; i++) begin
                bit in_lane = 1'b0;
                foreach (q[k]) if (q[k] == i) in_lane = 1'b1;
                if (!free_m[i] && !in_lane) owned.push_back(i);
            end
            for (int p = 0; p < N; p++) begin
                dv[p]  = ($urandom_range(0, 9) < 6);
                idx[p] = (owned.size() > 0 && $urandom_range(0, 9) < 8)
                         ? owned[$urandom_range(0, owned.size() - 1)] : int'($urandom_range(0, WIDTH - 1));
            end
            step("rand", int'($urandom_range(0, 3)), dv, idx[0], idx[1], idx[2]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
